// File: rtl/rsa_mp_mult_seq_pkg.sv
// Shared definitions for the multi-precision multiplier: word width, multiplier latency, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package rsa_mp_mult_seq_pkg;

    localparam int WORD_W   = 32;
    localparam int MULT_LAT = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Counter width able to index 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rsa_mp_mult_seq_mult.sv
// 32x32->64 unsigned multiplier with registered inputs and output (Gowin_MULT behaviour).
// Latency: operands presented in cycle c give dout in cycle c+2 while ce is held high.
// Backpressure: none; ce freezes every pipeline register, sync reset clears them.
// Ports: clk, reset (sync, high), ce, a/b (32b operands), dout (64b product).
module rsa_mp_mult_seq_mult (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] dout
);

    logic [31:0] a_q;
    logic [31:0] b_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q  <= '0;
            b_q  <= '0;
            dout <= '0;
        end else if (ce) begin
            a_q  <= a;
            b_q  <= b;
            dout <= {32'd0, a_q} * {32'd0, b_q};
        end
    end

endmodule

// File: rtl/rsa_mp_mult_seq.sv
// Operand-scanning multi-precision multiplier: product = op_a * op_b over NW 32-bit words.
// Latency: start accepted in cycle 0 -> done pulse in cycle NW*NW+3; busy over cycles 1..NW*NW+3.
// Backpressure: start is only taken in IDLE; it is ignored while busy (including the DONE cycle).
// Ports: clk, reset (sync, high), start, op_a/op_b (NW words, sampled on accept),
//        busy, done (1-cycle pulse), product (2*NW words, held until the next accept).
module rsa_mp_mult_seq
    import rsa_mp_mult_seq_pkg::*;
#(
    parameter int NW = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [NW*WORD_W-1:0]     op_a,
    input  logic [NW*WORD_W-1:0]     op_b,
    output logic                     busy,
    output logic                     done,
    output logic [2*NW*WORD_W-1:0]   product
);

    localparam int CNT_W = cnt_w(NW);
    localparam int IDX_W = cnt_w(2 * NW);
    localparam int DRN_W = cnt_w(MULT_LAT);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NW - 1);
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(MULT_LAT - 1);

    state_t              state;
    state_t              state_nxt;
    logic                accept;
    logic                issue;
    logic                mult_ce;
    logic                last_issue;

    logic [CNT_W-1:0]    i_cnt;
    logic [CNT_W-1:0]    j_cnt;
    logic [DRN_W-1:0]    drn_cnt;

    logic [WORD_W-1:0]   a_w [NW];
    logic [WORD_W-1:0]   b_w [NW];
    logic [WORD_W-1:0]   p_w [2*NW];
    logic [WORD_W-1:0]   carry;

    logic [WORD_W-1:0]   mult_a;
    logic [WORD_W-1:0]   mult_b;
    logic [2*WORD_W-1:0] mult_dout;

    // Issue tags riding alongside the multiplier pipeline.
    logic                s1_vld, s2_vld;
    logic [CNT_W-1:0]    s1_i, s2_i;
    logic [CNT_W-1:0]    s1_j, s2_j;
    logic                s1_last, s2_last;

    logic [IDX_W-1:0]    lo_idx;
    logic [IDX_W-1:0]    hi_idx;
    logic [2*WORD_W-1:0] acc_t;

    assign last_issue = (i_cnt == LAST_IDX) && (j_cnt == LAST_IDX);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        issue     = 1'b0;
        mult_ce   = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                issue   = 1'b1;
                mult_ce = 1'b1;
                if (last_issue) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // ce must stay high so the multiplier output register captures the tail.
                mult_ce = 1'b1;
                if (drn_cnt == DRN_LAST) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------- counters
    always_ff @(posedge clk) begin
        if (reset || accept) begin
            i_cnt   <= '0;
            j_cnt   <= '0;
            drn_cnt <= '0;
        end else begin
            if (issue) begin
                if (j_cnt == LAST_IDX) begin
                    j_cnt <= '0;
                    i_cnt <= i_cnt + CNT_W'(1);
                end else begin
                    j_cnt <= j_cnt + CNT_W'(1);
                end
            end
            drn_cnt <= (state == ST_DRAIN) ? drn_cnt + DRN_W'(1) : '0;
        end
    end

    // Operands are plain data registers; only accept loads them.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < NW; k++) begin
                a_w[k] <= op_a[k*WORD_W +: WORD_W];
                b_w[k] <= op_b[k*WORD_W +: WORD_W];
            end
        end
    end

    // ---------------------------------------------------------------- multiplier
    assign mult_a = a_w[i_cnt];
    assign mult_b = b_w[j_cnt];

    rsa_mp_mult_seq_mult u_mult (
        .clk   (clk),
        .reset (reset),
        .ce    (mult_ce),
        .a     (mult_a),
        .b     (mult_b),
        .dout  (mult_dout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld  <= 1'b0;
            s2_vld  <= 1'b0;
            s1_i    <= '0;
            s2_i    <= '0;
            s1_j    <= '0;
            s2_j    <= '0;
            s1_last <= 1'b0;
            s2_last <= 1'b0;
        end else begin
            s1_vld  <= issue;
            s1_i    <= i_cnt;
            s1_j    <= j_cnt;
            s1_last <= (j_cnt == LAST_IDX);
            s2_vld  <= s1_vld;
            s2_i    <= s1_i;
            s2_j    <= s1_j;
            s2_last <= s1_last;
        end
    end

    // ---------------------------------------------------------------- accumulate
    // Worst case (2^32-1) + (2^32-1)^2 + (2^32-1) = 2^64-1, so 64 bits never overflow.
    assign lo_idx = IDX_W'(s2_i) + IDX_W'(s2_j);
    assign hi_idx = IDX_W'(s2_i) + IDX_W'(NW);
    assign acc_t  = {32'd0, p_w[lo_idx]} + mult_dout + {32'd0, carry};

    always_ff @(posedge clk) begin
        if (reset || accept) begin
            for (int k = 0; k < 2*NW; k++) begin
                p_w[k] <= '0;
            end
            carry <= '0;
        end else if (s2_vld) begin
            p_w[lo_idx] <= acc_t[WORD_W-1:0];
            if (s2_last) begin
                // Row end: the carry becomes the row's top word (still zero before this write).
                p_w[hi_idx] <= acc_t[2*WORD_W-1:WORD_W];
                carry       <= '0;
            end else begin
                carry       <= acc_t[2*WORD_W-1:WORD_W];
            end
        end
    end

    genvar g;
    for (g = 0; g < 2*NW; g++) begin : g_prod
        assign product[g*WORD_W +: WORD_W] = p_w[g];
    end

endmodule

// File: tb/tb_rsa_mp_mult_seq.sv
module tb_rsa_mp_mult_seq;

    localparam int LAT4  = 4*4 + 3;     // 19
    localparam int LAT32 = 32*32 + 3;   // 1027

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // NW=4 instance
    logic         reset, start, busy, done;
    logic [127:0] op_a, op_b;
    logic [255:0] product;

    rsa_mp_mult_seq #(.NW(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op_a    (op_a),
        .op_b    (op_b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    // NW=32 instance
    logic          reset32, start32, busy32, done32;
    logic [1023:0] a32, b32;
    logic [2047:0] product32;

    rsa_mp_mult_seq #(.NW(32)) dut32 (
        .clk     (clk),
        .reset   (reset32),
        .start   (start32),
        .op_a    (a32),
        .op_b    (b32),
        .busy    (busy32),
        .done    (done32),
        .product (product32)
    );

    typedef struct {
        logic [255:0] prod;
        int           cyc;
    } exp4_t;

    typedef struct {
        logic [2047:0] prod;
        int            cyc;
    } exp32_t;

    exp4_t  q4[$];
    exp32_t q32[$];
    logic   fin32 = 1'b0;

    localparam logic [127:0] ONES128 = {128{1'b1}};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    task automatic push4(input logic [255:0] prod, input int done_cyc);
        exp4_t e;
        e.prod = prod;
        e.cyc  = done_cyc;
        q4.push_back(e);
    endtask

    // Launch one operation in the current (idle) cycle and wait until it is back in IDLE.
    task automatic run_op(input logic [127:0] a, input logic [127:0] b, input logic [255:0] prod);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        push4(prod, cyc + LAT4);
        tick;
        start = 1'b0;
        repeat (LAT4 + 1) tick;
    endtask

    // ---------------------------------------------------------------- monitors
    always @(negedge clk) begin : mon4
        exp4_t e;
        if (done === 1'b1) begin
            if (q4.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done4_spurious cyc=%0d product=%h", cyc, product);
            end else begin
                e = q4.pop_front();
                checks++;
                if (product !== e.prod) begin
                    errors++;
                    $display("FAIL product4 cyc=%0d got=%h exp=%h", cyc, product, e.prod);
                end
                checks++;
                if (cyc != e.cyc) begin
                    errors++;
                    $display("FAIL done4_cycle got=%0d exp=%0d", cyc, e.cyc);
                end
            end
        end
    end

    always @(negedge clk) begin : mon32
        exp32_t e;
        if (done32 === 1'b1) begin
            if (q32.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done32_spurious cyc=%0d", cyc);
            end else begin
                e = q32.pop_front();
                checks++;
                if (product32 !== e.prod) begin
                    errors++;
                    $display("FAIL product32 cyc=%0d got_lo=%h exp_lo=%h got_hi=%h exp_hi=%h",
                             cyc, product32[127:0], e.prod[127:0],
                             product32[2047:1920], e.prod[2047:1920]);
                end
                checks++;
                if (cyc != e.cyc) begin
                    errors++;
                    $display("FAIL done32_cycle got=%0d exp=%0d", cyc, e.cyc);
                end
            end
        end
    end

    // ---------------------------------------------------------------- NW=32 stimulus
    initial begin : stim32
        int            c0;
        exp32_t        e;
        logic [2047:0] wa, wb;
        reset32 = 1'b1;
        start32 = 1'b0;
        a32     = '0;
        b32     = '0;
        repeat (3) tick;
        reset32 = 1'b0;
        tick;
        c0      = cyc;
        start32 = 1'b1;
        for (int n = 0; n < 3; n++) begin
            if (n == 0) begin
                a32 = {1024{1'b1}};
                b32 = {1024{1'b1}};
            end else begin
                for (int w = 0; w < 32; w++) begin
                    a32[w*32 +: 32] = $urandom;
                    b32[w*32 +: 32] = $urandom;
                end
            end
            wa     = {1024'd0, a32};
            wb     = {1024'd0, b32};
            e.prod = wa * wb;
            e.cyc  = c0 + n*(LAT32 + 1) + LAT32;
            q32.push_back(e);
            repeat (LAT32 + 1) tick;
        end
        start32 = 1'b0;
        for (int k = 0; k < 100 && q32.size() != 0; k++) tick;
        if (q32.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout32 pending=%0d exp=0", q32.size());
        end
        fin32 = 1'b1;
    end

    // ---------------------------------------------------------------- NW=4 stimulus
    initial begin : stim4
        int           c0;
        logic [255:0] wa, wb;
        reset = 1'b1;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        repeat (3) tick;
        reset = 1'b0;
        tick;

        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_product", product, 0);
        chk("rst_ce", dut.mult_ce, 0);

        // 1: 1*1, busy profile over cycles 0..20
        c0    = cyc;
        op_a  = 128'd1;
        op_b  = 128'd1;
        start = 1'b1;
        push4(256'd1, c0 + LAT4);
        for (int k = 0; k <= LAT4 + 1; k++) begin
            chk("busy_t1", busy, (k >= 1 && k <= LAT4));
            tick;
            start = 1'b0;
        end

        // 2: all-ones squared
        run_op(ONES128, ONES128,
               {128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE, 128'h1});

        // 3: one-word all-ones times all-ones, row-top carry words
        run_op(128'hFFFFFFFF, ONES128,
               256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000001);

        // 4: stray starts while busy, operands changed after accept
        c0    = cyc;
        op_a  = 128'h2_00000003;
        op_b  = 128'd5;
        start = 1'b1;
        push4(256'hA_0000000F, c0 + LAT4);
        tick;
        start = 1'b0;
        op_a  = 128'd6;
        op_b  = 128'd7;
        while (cyc < c0 + 5) tick;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("busy_t4_c6", busy, 1);
        while (cyc < c0 + LAT4) tick;
        start = 1'b1;                 // DONE cycle: ignored
        tick;                         // cycle 20: IDLE, accepted
        chk("busy_t4_c20", busy, 0);
        push4(256'd42, cyc + LAT4);
        tick;
        start = 1'b0;
        chk("busy_t4_c21", busy, 1);
        repeat (LAT4 + 1) tick;

        // 5: reset in cycle 8 aborts the operation
        c0    = cyc;
        op_a  = ONES128;
        op_b  = ONES128;
        start = 1'b1;
        tick;
        start = 1'b0;
        while (cyc < c0 + 8) tick;
        reset = 1'b1;
        tick;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_product", product, 0);
        chk("abort_ce", dut.mult_ce, 0);
        reset = 1'b0;
        repeat (30) tick;
        run_op(128'h10000, 128'h10000, 256'h1_00000000);

        // 6: back-to-back random with start held high
        c0    = cyc;
        start = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            op_a = {$urandom, $urandom, $urandom, $urandom};
            op_b = {$urandom, $urandom, $urandom, $urandom};
            wa   = {128'd0, op_a};
            wb   = {128'd0, op_b};
            push4(wa * wb, c0 + n*(LAT4 + 1) + LAT4);
            repeat (LAT4 + 1) tick;
        end
        start = 1'b0;

        for (int k = 0; k < 100 && q4.size() != 0; k++) tick;
        if (q4.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout4 pending=%0d exp=0", q4.size());
        end
        for (int k = 0; k < 5000 && !fin32; k++) tick;
        if (!fin32) begin
            checks++;
            errors++;
            $display("FAIL timeout32_wait got=0 exp=1");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
